display_scan_controller: RTL



---
 rtl/display_scan_controller_pkg.sv | 31 +++
 rtl/display_decoder.sv | 28 ++
 rtl/display_scan_controller.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/display_scan_controller_pkg.sv
// Shared constants for the display scan controller: segment codes, digit width,
// legal parameter ranges and the per-slot scan state type.
package display_scan_controller_pkg;

    localparam int unsigned DIGIT_W     = 4;
    localparam int unsigned SEG_W       = 7;

    localparam int unsigned NDIGITS_MIN = 1;
    localparam int unsigned NDIGITS_MAX = 8;
    localparam int unsigned DIV_MIN     = 2;
    localparam int unsigned GUARD_MIN   = 1;

    // Segment patterns, bit order {g,f,e,d,c,b,a}, active-high.
    localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b1111101;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b1101111;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

    typedef enum logic {
        ST_GUARD = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

endpackage

// File: rtl/display_decoder.sv
// BCD to seven-segment decoder (combinational). Codes 10..15 decode to blank.
//   i_bcd     : 4-bit BCD digit
//   o_seg_c   : segments {g,f,e,d,c,b,a}, active-high
module display_decoder
    import display_scan_controller_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_bcd,
    output logic [SEG_W-1:0]   o_seg_c
);

    always_comb begin
        o_seg_c = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg_c = SEG_0;
            4'd1:    o_seg_c = SEG_1;
            4'd2:    o_seg_c = SEG_2;
            4'd3:    o_seg_c = SEG_3;
            4'd4:    o_seg_c = SEG_4;
            4'd5:    o_seg_c = SEG_5;
            4'd6:    o_seg_c = SEG_6;
            4'd7:    o_seg_c = SEG_7;
            4'd8:    o_seg_c = SEG_8;
            4'd9:    o_seg_c = SEG_9;
            default: o_seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexed seven-segment scan controller with double-buffered BCD word,
// per-slot dead-time and optional leading-zero suppression.
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_load           : strobe capturing i_value / i_dp_mask into the shadow buffer
//   i_value          : packed BCD, digit k at [4k+3:4k]
//   i_dp_mask        : per-digit decimal point enables
//   i_blank_lz       : leading-zero suppression enable (live)
//   o_seg, o_dp      : segments {g..a} and decimal point, active-high
//   o_an             : one-hot digit enable
//   o_frame_tick     : pulse on the last cycle of the last slot
module display_scan_controller
    import display_scan_controller_pkg::*;
#(
    parameter int unsigned NDIGITS = 4,
    parameter int unsigned DIV     = 50000,
    parameter int unsigned GUARD   = 500
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_load,
    input  logic [DIGIT_W*NDIGITS-1:0] i_value,
    input  logic [NDIGITS-1:0]         i_dp_mask,
    input  logic                       i_blank_lz,
    output logic [SEG_W-1:0]           o_seg,
    output logic                       o_dp,
    output logic [NDIGITS-1:0]         o_an,
    output logic                       o_frame_tick
);

    localparam int unsigned CNT_W = $clog2(DIV);
    localparam int unsigned IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int unsigned VAL_W = DIGIT_W * NDIGITS;

    scan_state_t          r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [VAL_W-1:0]     r_shadow_value;
    logic [NDIGITS-1:0]   r_shadow_dp;
    logic                 r_pending;
    logic [VAL_W-1:0]     r_active_value;
    logic [NDIGITS-1:0]   r_active_dp;
    logic [SEG_W-1:0]     r_seg;
    logic                 r_dp;
    logic [NDIGITS-1:0]   r_an;
    logic                 r_frame_tick;

    scan_state_t          w_state_next;
    logic                 w_cnt_wrap;
    logic                 w_frame_end;
    logic [CNT_W-1:0]     w_cnt_next;
    logic [IDX_W-1:0]     w_idx_next;
    logic [VAL_W-1:0]     w_shadow_value_next;
    logic [NDIGITS-1:0]   w_shadow_dp_next;
    logic                 w_pending_next;
    logic [VAL_W-1:0]     w_active_value_next;
    logic [NDIGITS-1:0]   w_active_dp_next;
    logic [SEG_W-1:0]     w_seg_next;
    logic                 w_dp_next;
    logic [NDIGITS-1:0]   w_an_next;
    logic                 w_frame_tick_next;
    logic [DIGIT_W-1:0]   w_digit;
    logic [SEG_W-1:0]     w_dec_seg;
    logic [NDIGITS-1:0]   w_supp;

    // Slot counter and digit index advance.
    always_comb begin
        w_cnt_wrap  = (r_cnt == CNT_W'(DIV - 1));
        w_frame_end = w_cnt_wrap && (r_idx == IDX_W'(NDIGITS - 1));
        w_cnt_next  = w_cnt_wrap ? '0 : r_cnt + CNT_W'(1);
        w_idx_next  = r_idx;
        if (w_cnt_wrap) begin
            w_idx_next = (r_idx == IDX_W'(NDIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
        end
    end

    // Double buffer: a load on the frame boundary goes straight to active.
    always_comb begin
        w_shadow_value_next = r_shadow_value;
        w_shadow_dp_next    = r_shadow_dp;
        w_pending_next      = r_pending;
        w_active_value_next = r_active_value;
        w_active_dp_next    = r_active_dp;
        if (w_frame_end) begin
            if (i_load) begin
                w_active_value_next = i_value;
                w_active_dp_next    = i_dp_mask;
                w_pending_next      = 1'b0;
            end else if (r_pending) begin
                w_active_value_next = r_shadow_value;
                w_active_dp_next    = r_shadow_dp;
                w_pending_next      = 1'b0;
            end
        end else if (i_load) begin
            w_shadow_value_next = i_value;
            w_shadow_dp_next    = i_dp_mask;
            w_pending_next      = 1'b1;
        end
    end

    // Digit k is suppressed when it and every digit above it are zero.
    always_comb begin : p_lz
        logic zero_above;
        zero_above = 1'b1;
        w_supp     = '0;
        for (int k = int'(NDIGITS) - 1; k >= 1; k--) begin
            zero_above = zero_above && (r_active_value[k*DIGIT_W +: DIGIT_W] == '0);
            w_supp[k]  = i_blank_lz && zero_above;
        end
    end

    // Outputs are computed for the upcoming slot position so they line up with r_cnt/r_idx.
    assign w_digit = r_active_value[DIGIT_W*w_idx_next +: DIGIT_W];

    display_decoder u_decoder (
        .i_bcd   (w_digit),
        .o_seg_c (w_dec_seg)
    );

    // Scan FSM: next state and registered-output values.
    always_comb begin
        w_state_next      = r_state;
        w_an_next         = '0;
        w_seg_next        = SEG_BLANK;
        w_dp_next         = 1'b0;
        w_frame_tick_next = (w_cnt_next == CNT_W'(DIV - 1)) &&
                            (w_idx_next == IDX_W'(NDIGITS - 1));
        case (r_state)
            ST_GUARD: if (w_cnt_next == CNT_W'(GUARD)) w_state_next = ST_SHOW;
            ST_SHOW:  if (w_cnt_wrap)                  w_state_next = ST_GUARD;
            default:  w_state_next = ST_GUARD;
        endcase
        if ((w_state_next == ST_SHOW) && !w_supp[w_idx_next]) begin
            w_an_next  = NDIGITS'(1) << w_idx_next;
            w_seg_next = w_dec_seg;
            w_dp_next  = r_active_dp[w_idx_next];
        end
    end

    // State, buffers and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= ST_GUARD;
            r_cnt          <= '0;
            r_idx          <= '0;
            r_shadow_value <= '0;
            r_shadow_dp    <= '0;
            r_pending      <= 1'b0;
            r_active_value <= '0;
            r_active_dp    <= '0;
            r_seg          <= '0;
            r_dp           <= 1'b0;
            r_an           <= '0;
            r_frame_tick   <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_cnt          <= w_cnt_next;
            r_idx          <= w_idx_next;
            r_shadow_value <= w_shadow_value_next;
            r_shadow_dp    <= w_shadow_dp_next;
            r_pending      <= w_pending_next;
            r_active_value <= w_active_value_next;
            r_active_dp    <= w_active_dp_next;
            r_seg          <= w_seg_next;
            r_dp           <= w_dp_next;
            r_an           <= w_an_next;
            r_frame_tick   <= w_frame_tick_next;
        end
    end

    assign o_seg        = r_seg;
    assign o_dp         = r_dp;
    assign o_an         = r_an;
    assign o_frame_tick = r_frame_tick;

endmodule
